// File: rtl/countdown_pkg.sv
// Shared types for the preloadable countdown timer.
package countdown_pkg;

    // IDLE: nothing loaded yet; ARMED: value captured, waiting for start;
    // RUN: decrementing on enable; EXPIRED: reached zero, waiting for restart.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RUN     = 2'd2,
        EXPIRED = 2'd3
    } state_e;

endpackage

// File: rtl/countdown_timer.sv
// Preloadable down-counter with a registered one-cycle expiry tick and
// optional automatic reload of the captured value.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] v,
    input  logic             start,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tick_q, tick_d;

    // Next-state decode: ld overrides everything, then start, then en.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tick_d   = 1'b0;

        if (ld) begin
            // Loading aborts any countdown in progress without a tick.
            count_d  = v;
            reload_d = v;
            state_d  = ARMED;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                ARMED: begin
                    if (start) begin
                        if (count_q != '0) begin
                            state_d = RUN;
                        end else begin
                            // Zero preload expires straight away.
                            state_d = EXPIRED;
                            tick_d  = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (en) begin
                        if (count_q > ONE) begin
                            count_d = count_q - ONE;
                        end else begin
                            // Final step: count would reach zero this cycle.
                            tick_d = 1'b1;
                            if (AUTO_RELOAD) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = EXPIRED;
                            end
                        end
                    end
                end
                EXPIRED: begin
                    if (start) begin
                        if (reload_q != '0) begin
                            count_d = reload_q;
                            state_d = RUN;
                        end else begin
                            // Nothing to count: expire again immediately.
                            tick_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, count, reload value and tick register; reset clears all of them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tick_q   <= tick_d;
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign busy  = (state_q == RUN);

endmodule
